// File: rtl/vga_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the VGA raster timing generator: default 640x480@60
// porch/sync geometry, derived totals and sync windows, and sync polarity
// encodings. Imported by the interface, the axis counter and the top level.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Coordinate width for hpos/vpos; totals must fit in this many bits.
  localparam int COORD_W   = 10;
  localparam int AXIS_MAX  = 1024;

  // Default 640x480@60 horizontal geometry (pixels).
  localparam int DEF_H_DISP = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;

  // Default 640x480@60 vertical geometry (lines).
  localparam int DEF_V_DISP = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  // Derived totals and inclusive sync windows for the defaults.
  localparam int DEF_H_TOTAL      = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_DISP + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_START = DEF_V_DISP + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  // Sync polarity: the level the sync output takes while active.
  localparam logic POL_ACTIVE_LOW  = 1'b0;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Raster timing bundle from the timing generator to the pixel stage.
//   pix_ce        pixel advance strobe
//   hpos/vpos     current column/line
//   hsync/vsync   sync outputs at configured polarity
//   display_on    inside the visible area
//   line_start    new line entered (one clk)
//   frame_start   (0,0) entered (one clk)
//   vblank_start  (0,V_DISP) entered (one clk)
//   frame_no      completed-frame count (FRAME_W bits)
// master: driven by vga_timing_gen; slave: consumer.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if
  import vga_timing_pkg::*;
#(
  parameter int FRAME_W = 9
);
  logic               pix_ce;
  logic [COORD_W-1:0] hpos;
  logic [COORD_W-1:0] vpos;
  logic               hsync;
  logic               vsync;
  logic               display_on;
  logic               line_start;
  logic               frame_start;
  logic               vblank_start;
  logic [FRAME_W-1:0] frame_no;

  modport master (
    output pix_ce, hpos, vpos, hsync, vsync, display_on,
           line_start, frame_start, vblank_start, frame_no
  );

  modport slave (
    input  pix_ce, hpos, vpos, hsync, vsync, display_on,
           line_start, frame_start, vblank_start, frame_no
  );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// Modulo-N position counter for one raster axis with an increment enable.
// Resets to N-1 so the first increment lands on 0.
//   clk, rst_n  clock, async active-low reset
//   inc         advance by one (wrapping N-1 -> 0)
//   count       registered position
//   at_last     count == N-1 (the next increment wraps)
//   disp_next   combinational: next position is inside [0, DISP-1]
//   sync        registered sync flag at POL, decoded from the next position
//               so it lines up with count in the same cycle
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   N          = DEF_H_TOTAL,
  parameter int   DISP       = DEF_H_DISP,
  parameter int   SYNC_START = DEF_H_SYNC_START,
  parameter int   SYNC_END   = DEF_H_SYNC_END,
  parameter logic POL        = POL_ACTIVE_LOW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  output logic [COORD_W-1:0] count,
  output logic               at_last,
  output logic               disp_next,
  output logic               sync
);

  logic [COORD_W-1:0] count_next;
  logic               sync_next;

  assign at_last = (count == COORD_W'(N - 1));

  // Next position and window decode of that next position.
  always_comb begin
    count_next = count;
    if (inc) begin
      if (at_last) begin
        count_next = {COORD_W{1'b0}};
      end else begin
        count_next = count + COORD_W'(1'b1);
      end
    end else begin
      count_next = count;
    end
    disp_next = (count_next < COORD_W'(DISP));
    if ((count_next >= COORD_W'(SYNC_START)) && (count_next <= COORD_W'(SYNC_END))) begin
      sync_next = POL;
    end else begin
      sync_next = ~POL;
    end
  end

  // Position and sync registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= COORD_W'(N - 1);
      sync  <= ~POL;
    end else begin
      count <= count_next;
      sync  <= sync_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator: pixel prescaler, horizontal/vertical position
// counters, sync/display windows, line/frame/vblank strobes and a completed-
// frame counter. Every output is a flop and all are aligned to the same
// position: a flag seen next to (hpos,vpos) describes exactly that position.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   vif    vga_timing_gen_if.master carrying all timing outputs
// The interface FRAME_W must equal this module's FRAME_W.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_DISP  = DEF_H_DISP,
  parameter int   H_FP    = DEF_H_FP,
  parameter int   H_SYNC  = DEF_H_SYNC,
  parameter int   H_BP    = DEF_H_BP,
  parameter int   V_DISP  = DEF_V_DISP,
  parameter int   V_FP    = DEF_V_FP,
  parameter int   V_SYNC  = DEF_V_SYNC,
  parameter int   V_BP    = DEF_V_BP,
  parameter logic H_POL   = POL_ACTIVE_LOW,
  parameter logic V_POL   = POL_ACTIVE_LOW,
  parameter int   PIX_DIV = 1,
  parameter int   FRAME_W = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL      = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_DISP + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISP + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  if ((PIX_DIV < 1) || (PIX_DIV > 4)) begin : g_bad_pix_div
    $error("vga_timing_gen: PIX_DIV must be 1..4");
  end
  if ((H_TOTAL > AXIS_MAX) || (V_TOTAL > AXIS_MAX)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  localparam logic [1:0] PRE_LAST = 2'(PIX_DIV - 1);

  logic [1:0]         presc;
  logic [1:0]         presc_next;
  logic               adv;
  logic [COORD_W-1:0] hpos;
  logic [COORD_W-1:0] vpos;
  logic               h_last;
  logic               v_last;
  logic               h_disp_next;
  logic               v_disp_next;
  logic               hsync;
  logic               vsync;
  logic               pix_ce;
  logic               display_on;
  logic               line_start;
  logic               frame_start;
  logic               vblank_start;
  logic               line_start_next;
  logic               frame_start_next;
  logic               vblank_start_next;
  logic [FRAME_W-1:0] frame_no;

  // Advance happens on the edge closing the last prescaler clk of a pixel.
  // The strobes are set by that same edge, so they are high only in the first
  // clk of the newly entered pixel.
  always_comb begin
    adv = (presc == PRE_LAST);
    if (adv) begin
      presc_next = 2'd0;
    end else begin
      presc_next = presc + 2'd1;
    end
    line_start_next   = adv & h_last;
    frame_start_next  = line_start_next & v_last;
    vblank_start_next = line_start_next & (vpos == COORD_W'(V_DISP - 1));
  end

  vga_axis_counter #(
    .N          (H_TOTAL),
    .DISP       (H_DISP),
    .SYNC_START (H_SYNC_START),
    .SYNC_END   (H_SYNC_END),
    .POL        (H_POL)
  ) u_h_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (adv),
    .count     (hpos),
    .at_last   (h_last),
    .disp_next (h_disp_next),
    .sync      (hsync)
  );

  // Vertical axis steps only on the horizontal wrap, so vsync can only
  // change together with hpos returning to 0.
  vga_axis_counter #(
    .N          (V_TOTAL),
    .DISP       (V_DISP),
    .SYNC_START (V_SYNC_START),
    .SYNC_END   (V_SYNC_END),
    .POL        (V_POL)
  ) u_v_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (adv & h_last),
    .count     (vpos),
    .at_last   (v_last),
    .disp_next (v_disp_next),
    .sync      (vsync)
  );

  // Prescaler, pix_ce, display window, strobes and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= 2'd0;
      pix_ce       <= 1'b0;
      display_on   <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_no     <= {FRAME_W{1'b0}};
    end else begin
      presc        <= presc_next;
      pix_ce       <= (presc_next == PRE_LAST);
      display_on   <= h_disp_next & v_disp_next;
      line_start   <= line_start_next;
      frame_start  <= frame_start_next;
      vblank_start <= vblank_start_next;
      if (vblank_start_next) begin
        frame_no <= frame_no + FRAME_W'(1'b1);
      end else begin
        frame_no <= frame_no;
      end
    end
  end

  assign vif.pix_ce       = pix_ce;
  assign vif.hpos         = hpos;
  assign vif.vpos         = vpos;
  assign vif.hsync        = hsync;
  assign vif.vsync        = vsync;
  assign vif.display_on   = display_on;
  assign vif.line_start   = line_start;
  assign vif.frame_start  = frame_start;
  assign vif.vblank_start = vblank_start;
  assign vif.frame_no     = frame_no;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Four generator instances (full 640x480 at PIX_DIV 1 and 2, two small
// geometries with PIX_DIV 1/3, narrow frame counters and mixed polarity)
// share clk and rst_n. A closed-form model derives every output from the
// number of clk edges since reset release; randomized reset pulses restart it.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct {
    int hd, hfp, hs, hbp, vd, vfp, vs, vbp, hpol, vpol, div, fw;
  } cfg_t;

  typedef struct {
    int pix_ce, hpos, vpos, hsync, vsync, disp, ls, fs, vbs, frame;
  } exp_t;

  cfg_t c0 = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1, 9};
  cfg_t c1 = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 9};
  cfg_t c2 = '{8, 2, 3, 3, 6, 1, 2, 1, 1, 0, 1, 2};
  cfg_t c3 = '{8, 2, 3, 3, 6, 1, 2, 1, 0, 1, 3, 3};

  logic  clk = 1'b0;
  logic  rst_n = 1'b1;
  longint edges;
  int    checks = 0;
  int    failures = 0;
  bit    chk_en = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.FRAME_W(9)) if0 ();
  vga_timing_gen_if #(.FRAME_W(9)) if1 ();
  vga_timing_gen_if #(.FRAME_W(2)) if2 ();
  vga_timing_gen_if #(.FRAME_W(3)) if3 ();

  vga_timing_gen #(.PIX_DIV(1), .FRAME_W(9)) u0 (.clk(clk), .rst_n(rst_n), .vif(if0));
  vga_timing_gen #(.PIX_DIV(2), .FRAME_W(9)) u1 (.clk(clk), .rst_n(rst_n), .vif(if1));
  vga_timing_gen #(
    .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0), .PIX_DIV(1), .FRAME_W(2)
  ) u2 (.clk(clk), .rst_n(rst_n), .vif(if2));
  vga_timing_gen #(
    .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b1), .PIX_DIV(3), .FRAME_W(3)
  ) u3 (.clk(clk), .rst_n(rst_n), .vif(if3));

  // Clk edges seen since reset release: the model's only time base.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  // Expected outputs after n edges since release (rn = current rst_n).
  function automatic exp_t model(input cfg_t c, input longint n, input logic rn);
    exp_t   e;
    longint ht, vt, a, l, h, v;
    ht = c.hd + c.hfp + c.hs + c.hbp;
    vt = c.vd + c.vfp + c.vs + c.vbp;
    e.pix_ce = (rn && n >= 1 && (n % c.div) == c.div - 1) ? 1 : 0;
    a = rn ? n / c.div : 0;
    if (a == 0) begin
      e.hpos = int'(ht - 1); e.vpos = int'(vt - 1);
      e.hsync = 1 - c.hpol;  e.vsync = 1 - c.vpol;
      e.disp = 0; e.ls = 0; e.fs = 0; e.vbs = 0; e.frame = 0;
    end else begin
      l = a - 1;
      h = l % ht;
      v = (l / ht) % vt;
      e.hpos = int'(h); e.vpos = int'(v);
      e.hsync = (h >= c.hd + c.hfp && h < c.hd + c.hfp + c.hs) ? c.hpol : 1 - c.hpol;
      e.vsync = (v >= c.vd + c.vfp && v < c.vd + c.vfp + c.vs) ? c.vpol : 1 - c.vpol;
      e.disp = (h < c.hd && v < c.vd) ? 1 : 0;
      e.ls = ((n % c.div) == 0 && h == 0) ? 1 : 0;
      e.fs = (e.ls == 1 && v == 0) ? 1 : 0;
      e.vbs = (e.ls == 1 && v == c.vd) ? 1 : 0;
      if (l >= c.vd * ht) e.frame = int'(((l - c.vd * ht) / (ht * vt) + 1) % (64'd1 << c.fw));
      else e.frame = 0;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_inst(input string nm, input exp_t e,
                            input logic pc, input logic [9:0] hp, input logic [9:0] vp,
                            input logic hs, input logic vs, input logic dn,
                            input logic ls, input logic fs, input logic vb,
                            input logic [31:0] fr);
    chk({nm, ".pix_ce"}, {31'd0, pc}, e.pix_ce);
    chk({nm, ".hpos"}, {22'd0, hp}, e.hpos);
    chk({nm, ".vpos"}, {22'd0, vp}, e.vpos);
    chk({nm, ".hsync"}, {31'd0, hs}, e.hsync);
    chk({nm, ".vsync"}, {31'd0, vs}, e.vsync);
    chk({nm, ".display_on"}, {31'd0, dn}, e.disp);
    chk({nm, ".line_start"}, {31'd0, ls}, e.ls);
    chk({nm, ".frame_start"}, {31'd0, fs}, e.fs);
    chk({nm, ".vblank_start"}, {31'd0, vb}, e.vbs);
    chk({nm, ".frame_no"}, fr, e.frame);
  endtask

  // Per-cycle comparison of every instance against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check_inst("u0", model(c0, edges, rst_n), if0.pix_ce, if0.hpos, if0.vpos, if0.hsync,
                 if0.vsync, if0.display_on, if0.line_start, if0.frame_start,
                 if0.vblank_start, 32'(if0.frame_no));
      check_inst("u1", model(c1, edges, rst_n), if1.pix_ce, if1.hpos, if1.vpos, if1.hsync,
                 if1.vsync, if1.display_on, if1.line_start, if1.frame_start,
                 if1.vblank_start, 32'(if1.frame_no));
      check_inst("u2", model(c2, edges, rst_n), if2.pix_ce, if2.hpos, if2.vpos, if2.hsync,
                 if2.vsync, if2.display_on, if2.line_start, if2.frame_start,
                 if2.vblank_start, 32'(if2.frame_no));
      check_inst("u3", model(c3, edges, rst_n), if3.pix_ce, if3.hpos, if3.vpos, if3.hsync,
                 if3.vsync, if3.display_on, if3.line_start, if3.frame_start,
                 if3.vblank_start, 32'(if3.frame_no));
    end
  end

  initial begin
    exp_t e;

    // Hand-computed points pinning the model itself.
    e = model(c0, 64'd657, 1'b1);    chk("pin_h656_hpos", e.hpos, 656); chk("pin_h656_hsync", e.hsync, 0);
    e = model(c0, 64'd753, 1'b1);    chk("pin_h752_hsync", e.hsync, 1);
    e = model(c0, 64'd641, 1'b1);    chk("pin_h640_disp", e.disp, 0);
    e = model(c0, 64'd384001, 1'b1); chk("pin_vblank_vpos", e.vpos, 480); chk("pin_vblank_frame", e.frame, 1);
    e = model(c0, 64'd392001, 1'b1); chk("pin_v490_vsync", e.vsync, 0);
    e = model(c0, 64'd804001, 1'b1); chk("pin_frame2", e.frame, 2);
    e = model(c1, 64'd3, 1'b1);      chk("pin_div2_ls", e.ls, 0); chk("pin_div2_ce", e.pix_ce, 1);
    e = model(c2, 64'd577, 1'b1);    chk("pin_fw2_wrap", e.frame, 0); chk("pin_fw2_vbs", e.vbs, 1);

    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hpos", {22'd0, if0.hpos}, 799);
    chk("rst_vpos", {22'd0, if0.vpos}, 524);
    chk("rst_hsync", {31'd0, if0.hsync}, 1);
    chk("rst_vsync", {31'd0, if0.vsync}, 1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_hpos", {22'd0, if0.hpos}, 0);
    chk("first_vpos", {22'd0, if0.vpos}, 0);
    chk("first_disp", {31'd0, if0.display_on}, 1);
    chk("first_ls", {31'd0, if0.line_start}, 1);
    chk("first_fs", {31'd0, if0.frame_start}, 1);
    chk("first_u1_hpos", {22'd0, if1.hpos}, 799);

    repeat (5000) @(posedge clk);

    for (int ep = 0; ep < 14; ep++) begin
      repeat ($urandom_range(300, 3000)) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_u0_hpos", {22'd0, if0.hpos}, 799);
      chk("async_u2_hpos", {22'd0, if2.hpos}, 15);
      chk("async_u3_frame", 32'(if3.frame_no), 0);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #2 rst_n = 1'b1;
    end

    repeat (2000) @(posedge clk);
    @(negedge clk);
    #1 chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
